// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the sequencer run/stop/step controller.
// The stop-priority helper keeps the cause ordering in one place.
package seq_ctrl_pkg;

  localparam int DIV_W_DEF  = 8;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_USER = 2'd1,
    CAUSE_HALT = 2'd2,
    CAUSE_BKPT = 2'd3
  } stop_cause_t;

  // Highest-priority reason to stop at a boundary; a single step completing
  // reports as an operator stop.
  function automatic stop_cause_t pick_cause(input logic halt, input logic user,
                                             input logic bkpt, input logic step);
    if (halt)      return CAUSE_HALT;
    else if (user) return CAUSE_USER;
    else if (bkpt) return CAUSE_BKPT;
    else if (step) return CAUSE_USER;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/sequencer_run_controller_if.sv
// Front-panel / sequencer bundle seen by the run controller.
// master = panel + sequencer side, slave = the controller.
interface sequencer_run_controller_if
  import seq_ctrl_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              run_req;
  logic              stop_req;
  logic              step_req;
  logic [DIV_W-1:0]  rate_div;
  logic              instr_boundary;
  logic              halt_seen;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] bkpt_addr;
  logic              bkpt_en;
  logic              seq_clk_en;
  logic              running;
  logic              step_done;
  logic [1:0]        stop_cause;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output run_req, stop_req, step_req, rate_div, instr_boundary, halt_seen,
           pc, bkpt_addr, bkpt_en,
    input  seq_clk_en, running, step_done, stop_cause, instr_count
  );

  modport slave (
    input  run_req, stop_req, step_req, rate_div, instr_boundary, halt_seen,
           pc, bkpt_addr, bkpt_en,
    output seq_clk_en, running, step_done, stop_cause, instr_count
  );
endinterface

// File: rtl/seq_rate_divider.sv
// Advance-rate divider: tick every rate_div+1 enabled clocks, restartable.
module seq_rate_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  // Live compare: a lowered rate_div below cnt lets the counter wrap first.
  assign tick = en && (cnt == rate_div);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (en)      cnt <= (cnt == rate_div) ? '0 : cnt + DIV_W'(1);
  end
endmodule

// File: rtl/sequencer_run_controller.sv
// Run/stop/step controller: paces one-pulse advances to the relay sequencer
// and stops only at instruction boundaries (operator, HLT, breakpoint).
module sequencer_run_controller
  import seq_ctrl_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic                       clock,
  input logic                       reset_n,
  sequencer_run_controller_if.slave bus
);
  run_state_t        state;
  stop_cause_t       cause_q;
  stop_cause_t       cause_nx;
  logic              stop_pend;
  logic              halt_pend;
  logic              first;
  logic              seq_clk_en_q;
  logic              running_q;
  logic              step_done_q;
  logic [CNT_W-1:0]  instr_count_q;
  logic              tick;
  logic              div_clr;
  logic              div_en;
  logic              start;
  logic              bkpt_hit;
  logic              at_check;
  logic [ADDR_W-1:0] pc_cmp;
  logic [ADDR_W-1:0] bkpt_cmp;

  assign start   = (state == STOPPED) && (bus.run_req || bus.step_req);
  assign div_clr = start;
  assign div_en  = (state != STOPPED);

  seq_rate_divider #(.DIV_W(DIV_W)) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (div_clr),
    .en       (div_en),
    .rate_div (bus.rate_div),
    .tick     (tick)
  );

  assign pc_cmp   = bus.pc;
  assign bkpt_cmp = bus.bkpt_addr;
  assign bkpt_hit = bus.bkpt_en && (pc_cmp == bkpt_cmp);

  // first masks the resume boundary so a breakpoint or step can move off it.
  assign at_check = tick && bus.instr_boundary && !first;
  assign cause_nx = pick_cause(halt_pend, stop_pend, bkpt_hit, state == STEP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= STOPPED;
      cause_q       <= CAUSE_NONE;
      stop_pend     <= 1'b0;
      halt_pend     <= 1'b0;
      first         <= 1'b0;
      seq_clk_en_q  <= 1'b0;
      running_q     <= 1'b0;
      step_done_q   <= 1'b0;
      instr_count_q <= '0;
    end else begin
      seq_clk_en_q <= 1'b0;
      step_done_q  <= 1'b0;
      case (state)
        STOPPED: begin
          if (start) begin
            state     <= bus.run_req ? RUN : STEP;
            running_q <= 1'b1;
            first     <= 1'b1;
            stop_pend <= 1'b0;
            halt_pend <= 1'b0;
          end
        end
        RUN, STEP: begin
          if (bus.stop_req)  stop_pend <= 1'b1;
          if (bus.halt_seen) halt_pend <= 1'b1;
          if (tick) begin
            if (at_check && (cause_nx != CAUSE_NONE)) begin
              state       <= STOPPED;
              running_q   <= 1'b0;
              cause_q     <= cause_nx;
              step_done_q <= (state == STEP);
            end else begin
              seq_clk_en_q <= 1'b1;
              if (bus.instr_boundary) begin
                instr_count_q <= instr_count_q + CNT_W'(1);
                first         <= 1'b0;
              end
            end
          end
        end
        default: begin
          state     <= STOPPED;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.seq_clk_en  = seq_clk_en_q;
  assign bus.running     = running_q;
  assign bus.step_done   = step_done_q;
  assign bus.stop_cause  = cause_q;
  assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_sequencer_run_controller.sv
// Bench: relay-sequencer model around the controller, instruction-level
// outcome predictor, directed scenarios followed by randomized segments.
module tb_sequencer_run_controller;
  import seq_ctrl_pkg::*;

  localparam int DIV_W  = 8;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sequencer_run_controller_if #(.DIV_W(DIV_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) ifc();

  sequencer_run_controller #(.DIV_W(DIV_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  // Sequencer model: seq_len pulses per instruction, pc advances as an
  // instruction's last pulse completes. Boundary/pc reflect any advance in
  // flight this cycle, i.e. what the next advance will begin.
  int          seq_len = 8;
  int          seq_p;
  logic [15:0] seq_pc;
  logic [15:0] pc_init = 16'h0000;
  logic [15:0] halt_addr = 16'h0000;
  logic        halt_arm = 1'b0;
  logic        halt_q;
  logic        adv_wrap;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq_p  <= 0;
      seq_pc <= pc_init;
      halt_q <= 1'b0;
    end else begin
      halt_q <= ifc.seq_clk_en && (seq_p == 1) && halt_arm && (seq_pc == halt_addr);
      if (ifc.seq_clk_en) begin
        if (seq_p == seq_len - 1) begin
          seq_p  <= 0;
          seq_pc <= seq_pc + 16'd1;
        end else begin
          seq_p <= seq_p + 1;
        end
      end
    end
  end

  assign adv_wrap           = ifc.seq_clk_en && (seq_p == seq_len - 1);
  assign ifc.instr_boundary = ((seq_p == 0) && !ifc.seq_clk_en) || adv_wrap;
  assign ifc.pc             = adv_wrap ? seq_pc + 16'd1 : seq_pc;
  assign ifc.halt_seen      = halt_q;

  // Monitor: cycle index of every advance, count of step_done cycles.
  int cyc = 0;
  int adv_q[$];
  int sd_total = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (ifc.seq_clk_en) adv_q.push_back(cyc);
    if (ifc.step_done)  sd_total <= sd_total + 1;
  end

  int          checks = 0;
  int          failures = 0;
  int          t_rate = 0;
  logic        t_bkpt_en = 1'b0;
  logic [15:0] t_bkpt_addr = 16'h0000;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_cnt = 16'h0000;
  int          m_cause = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction-level outcome: each instruction costs seq_len advances; at
  // every boundary after the first, stop for halt > operator > bkpt > step.
  function automatic void predict(input bit step, input int k,
                                  output int n_exec, output int cause);
    logic [15:0] p = m_pc;
    bit first_i = 1'b1;
    bit hp = 1'b0;
    n_exec = 0;
    cause  = 0;
    for (int g = 0; g < 64; g++) begin
      if (!first_i) begin
        if (hp)                                cause = 2;
        else if (k > 0 && n_exec*seq_len >= k) cause = 1;
        else if (t_bkpt_en && p == t_bkpt_addr) cause = 3;
        else if (step)                         cause = 1;
        if (cause != 0) break;
      end
      hp = halt_arm && (p == halt_addr);
      p  = p + 16'd1;
      n_exec++;
      first_i = 1'b0;
    end
  endfunction

  task automatic drive_cfg();
    ifc.rate_div  = DIV_W'(t_rate);
    ifc.bkpt_en   = t_bkpt_en;
    ifc.bkpt_addr = t_bkpt_addr;
  endtask

  task automatic do_reset(input logic [15:0] pc0);
    pc_init = pc0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    m_pc = pc0; m_cnt = 16'h0000; m_cause = 0;
  endtask

  // One run/step segment from STOPPED until it stops; stop_req is pulsed
  // when the k-th advance of the segment is seen (k=0: never).
  task automatic run_seg(input string tag, input bit rq, input bit sq,
                         input bit step_model, input int k);
    int q0, sd0, c0, n_exec, cause, fall, n_adv, bad;
    bit sent;
    q0 = adv_q.size(); sd0 = sd_total; fall = -1; sent = 1'b0; bad = 0;
    drive_cfg();
    predict(step_model, k, n_exec, cause);
    c0 = cyc;
    ifc.run_req = rq; ifc.step_req = sq;
    @(posedge clock); #1;
    ifc.run_req = 1'b0; ifc.step_req = 1'b0;
    chk({tag, " running"}, 32'(ifc.running), 32'd1);
    for (int t = 0; t < 4000; t++) begin
      if (!ifc.running) begin fall = cyc; break; end
      if (k > 0 && !sent && (adv_q.size() - q0) == k) begin
        ifc.stop_req = 1'b1; sent = 1'b1;
      end else begin
        ifc.stop_req = 1'b0;
      end
      @(posedge clock); #1;
    end
    ifc.stop_req = 1'b0;
    chk({tag, " stopped"}, 32'(fall != -1), 32'd1);
    @(posedge clock); #1;
    n_adv = adv_q.size() - q0;
    chk({tag, " advances"}, 32'(n_adv), 32'(n_exec * seq_len));
    if (n_adv > 0) begin
      chk({tag, " first_adv"}, 32'(adv_q[q0]), 32'(c0 + 2 + t_rate));
      for (int i = q0 + 1; i < adv_q.size(); i++)
        if (adv_q[i] - adv_q[i-1] != t_rate + 1) bad++;
      chk({tag, " gaps"}, 32'(bad), 32'd0);
      chk({tag, " stop_time"}, 32'(fall), 32'(adv_q[adv_q.size()-1] + t_rate + 1));
    end
    chk({tag, " cause"}, 32'(ifc.stop_cause), 32'(cause));
    chk({tag, " count"}, 32'(ifc.instr_count), 32'(m_cnt + 16'(n_exec)));
    chk({tag, " step_done"}, 32'(sd_total - sd0), 32'(step_model));
    chk({tag, " step_done_low"}, 32'(ifc.step_done), 32'd0);
    m_pc    = m_pc + 16'(n_exec);
    m_cnt   = m_cnt + 16'(n_exec);
    m_cause = cause;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, k;
    bit st;
    ifc.run_req = 1'b0; ifc.stop_req = 1'b0; ifc.step_req = 1'b0;
    drive_cfg();

    // Reset state, rate 0, 8-pulse instructions, stop in the 4th.
    do_reset(16'h0000);
    chk("rst seq_clk_en", 32'(ifc.seq_clk_en), 32'd0);
    chk("rst running",    32'(ifc.running),    32'd0);
    chk("rst step_done",  32'(ifc.step_done),  32'd0);
    chk("rst cause",      32'(ifc.stop_cause), 32'd0);
    chk("rst count",      32'(ifc.instr_count), 32'd0);
    seq_len = 8; t_rate = 0;
    run_seg("run_rate0", 1'b1, 1'b0, 1'b0, 3*8 + 5);

    // Single step at rate 3 from a fresh reset.
    do_reset(16'h0000);
    t_rate = 3;
    run_seg("step_rate3", 1'b0, 1'b1, 1'b1, 0);

    // Operator stop at pulse 5 of a 12-pulse instruction.
    seq_len = 12; t_rate = 1;
    run_seg("stop_mid", 1'b1, 1'b0, 1'b0, 5);

    // Breakpoint at 0x0010, then resume past it.
    seq_len = 4; t_rate = 0; t_bkpt_en = 1'b1; t_bkpt_addr = 16'h0010;
    run_seg("bkpt_hit", 1'b1, 1'b0, 1'b0, 0);
    chk("bkpt pc", 32'(ifc.pc), 32'h10);
    run_seg("bkpt_resume", 1'b1, 1'b0, 1'b0, 2*4 + 1);

    // HLT, then HLT with a stop_req inside the same instruction.
    t_bkpt_en = 1'b0; seq_len = 6; t_rate = 2;
    halt_arm = 1'b1; halt_addr = m_pc + 16'd2;
    run_seg("halt", 1'b1, 1'b0, 1'b0, 0);
    halt_addr = m_pc + 16'd1;
    run_seg("halt_vs_stop", 1'b1, 1'b0, 1'b0, 6 + 3);
    halt_arm = 1'b0;

    // stop_req while stopped has no effect.
    a0 = adv_q.size();
    ifc.stop_req = 1'b1; @(posedge clock); #1; ifc.stop_req = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("idle_stop running", 32'(ifc.running), 32'd0);
    chk("idle_stop cause",   32'(ifc.stop_cause), 32'(m_cause));
    chk("idle_stop adv",     32'(adv_q.size() - a0), 32'd0);

    // Async reset between clock edges while running.
    t_rate = 0; seq_len = 5; drive_cfg();
    ifc.run_req = 1'b1; @(posedge clock); #1; ifc.run_req = 1'b0;
    repeat (20) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("arst seq_clk_en", 32'(ifc.seq_clk_en), 32'd0);
    chk("arst running",    32'(ifc.running),    32'd0);
    chk("arst cause",      32'(ifc.stop_cause), 32'd0);
    chk("arst count",      32'(ifc.instr_count), 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    m_pc = pc_init; m_cnt = 16'h0000; m_cause = 0;

    // run_req and step_req together select RUN.
    run_seg("run_and_step", 1'b1, 1'b1, 1'b0, 2*5 + 2);

    // Randomized segments.
    for (int r = 0; r < 10; r++) begin
      t_rate      = $urandom_range(0, 4);
      seq_len     = $urandom_range(4, 12);
      st          = ($urandom_range(0, 2) == 0);
      t_bkpt_en   = 1'($urandom_range(0, 1));
      t_bkpt_addr = m_pc + 16'($urandom_range(0, 5));
      halt_arm    = 1'($urandom_range(0, 1));
      halt_addr   = m_pc + 16'($urandom_range(0, 5));
      k = st ? 0 : $urandom_range(0, 4) * seq_len + $urandom_range(1, seq_len - 2);
      run_seg($sformatf("rand%0d", r), !st, st, st, k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sequencer_run_controller.md
Name: sequencer_run_controller

Overview:
- Front-panel run/stop/step controller for the relay-computer sequencer.
- Issues one-cycle advance pulses (seq_clk_en) that step the sequencer FSM one relay pulse at a time, at a programmable rate.
- Stops only at instruction boundaries: on operator stop, on an executed HLT, or on a PC breakpoint.
- Sits between the front-panel switches/decode logic and the sequencer FSM's clock-enable input.

Parameters:
- DIV_W, 8, width of the rate divider setting.
- ADDR_W, 16, width of program counter / breakpoint address.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run_req  in  1  one-cycle pulse: start free running.
- stop_req  in  1  one-cycle pulse: stop at next instruction boundary.
- step_req  in  1  one-cycle pulse: execute exactly one instruction.
- rate_div  in  DIV_W  ticks occur every rate_div+1 clocks.
- instr_boundary  in  1  sequencer FSM is in its first state; the next advance begins a fetch.
- halt_seen  in  1  one-cycle pulse from decode: HLT executed.
- pc  in  ADDR_W  current program counter.
- bkpt_addr  in  ADDR_W  breakpoint address.
- bkpt_en  in  1  breakpoint enable.
- seq_clk_en  out  1  one-cycle advance pulse to sequencer FSM.
- running  out  1  high in RUN or STEP.
- step_done  out  1  one-cycle pulse when a STEP completes.
- stop_cause  out  2  0 = reset/none, 1 = operator stop/step complete, 2 = HLT, 3 = breakpoint.
- instr_count  out  CNT_W  instructions started since reset.

Behaviour:
- Reset (async, reset_n = 0): state STOPPED, seq_clk_en = 0, running = 0, step_done = 0, stop_cause = 0, instr_count = 0, divider = 0, stop_pend = 0, halt_pend = 0, first = 0.
- States: STOPPED, RUN, STEP. Encoding goes in the package.
- Divider:
  - Counts only while running.
  - tick = (div_cnt == rate_div). On tick, div_cnt <= 0; otherwise div_cnt increments.
  - Cleared on entry to RUN or STEP, so the first tick comes rate_div+1 clocks after entry.
  - rate_div = 0 gives a tick every clock.
  - A rate_div change takes effect at the next compare. If div_cnt > rate_div, the counter wraps at its full width before matching.
- STOPPED:
  - seq_clk_en = 0.
  - run_req -> RUN; else step_req -> STEP. run_req wins if both arrive together.
  - Either transition sets first = 1 and clears stop_pend and halt_pend.
  - stop_req is ignored.
- RUN/STEP stop check, on each tick:
  - If instr_boundary = 1 and first = 0, evaluate stop conditions in priority order: halt_pend (cause 2) > stop_pend (cause 1) > bkpt_en && pc == bkpt_addr (cause 3).
  - In STEP, any boundary with first = 0 stops with cause 1 unless a higher-priority cause applies.
  - On stop: go to STOPPED, do not emit seq_clk_en, update stop_cause. If leaving STEP, pulse step_done for one cycle the following cycle.
  - Otherwise: seq_clk_en = 1 for that clock. If instr_boundary = 1, increment instr_count (wraps modulo 2^CNT_W) and clear first.
- first suppresses the breakpoint and step-stop checks at the boundary where execution resumes. This lets execution continue off a breakpoint address.
- Pending flags:
  - stop_req in RUN/STEP sets stop_pend.
  - halt_seen sets halt_pend in any state other than STOPPED.
  - Both are sticky until the next entry to RUN/STEP.
- Latency: seq_clk_en is registered. It is high in the cycle after the tick is computed and never high for two consecutive cycles unless rate_div = 0.
- running = (state != STOPPED). Registered, updates with the state.
- A run_req or step_req arriving in RUN/STEP is ignored.
- A reset_n assertion mid-instruction aborts immediately. The sequencer FSM is reset by the same reset_n.

Decomposition:
- Package seq_ctrl_pkg holds:
  - the run_state_t enum {STOPPED, RUN, STEP};
  - the stop_cause_t enum {CAUSE_NONE, CAUSE_USER, CAUSE_HALT, CAUSE_BKPT};
  - default parameter constants.
- One sub-module, seq_rate_divider, holds the divider counter with clear and enable, and outputs tick.
- The FSM, pending flags and counter stay in the top module.

Test Plan:
- Reset with the sequencer model at 8 pulses/instruction, rate_div = 0; run_req -> seq_clk_en every clock from cycle 2; instr_count increments every 8 advances; running = 1.
- rate_div = 3, step_req with instr_boundary high -> seq_clk_en every 4th clock, 8 pulses for an 8-pulse instruction; stop at next boundary; step_done pulse; stop_cause = 1; instr_count = 1.
- RUN, stop_req mid-instruction (pulse 5 of 12) -> remaining 7 pulses issued, stop at boundary, stop_cause = 1, no advance at that boundary.
- bkpt_en = 1, bkpt_addr = 16'h0010, program reaches pc = 0x0010 -> stop with stop_cause = 3. run_req -> resumes past 0x0010 without re-stopping there.
- halt_seen pulse during an instruction -> stop at next boundary, stop_cause = 2. Simultaneous stop_req in the same window -> cause is still 2.
- reset_n dropped asynchronously mid-RUN, between clock edges -> all outputs 0 immediately. Simultaneous run_req + step_req from STOPPED -> RUN.
